// File: rtl/ioctl_load_pkg.sv
// ioctl_load_pkg: stream indices, scheduler state and game-select encodings
// shared by the ioctl load scheduler and its FSM.
package ioctl_load_pkg;

    localparam logic [7:0] IDX_ROM = 8'd0;
    localparam logic [7:0] IDX_MOD = 8'd1;
    localparam logic [7:0] IDX_DIP = 8'd254;

    typedef enum logic [1:0] {
        SETTLE,
        LOAD,
        RUN,
        HALT
    } state_e;

    typedef enum logic [1:0] {
        MOD_BWIDOW,
        MOD_GRAVITAR,
        MOD_LUNARBAT,
        MOD_SPACDUEL
    } mod_e;

    // One-hot game select, bit position equals the mod code.
    function automatic logic [3:0] mod_onehot(input mod_e m);
        logic [3:0] r;
        r = 4'b0001 << m;
        return r;
    endfunction

endpackage

// File: rtl/ioctl_load_fsm.sv
// ioctl_load_fsm: owns the core reset. Holds the core in reset while a ROM
// download is active, while reset is requested, and for RESET_HOLD cycles
// afterwards. With IOCTL_LOAD_LEN_CHECK_EN defined it also counts accepted
// ROM bytes and parks in HALT (load_short=1) after a short image.
module ioctl_load_fsm
    import ioctl_load_pkg::*;
#(
    parameter int unsigned RESET_HOLD = 16
`ifdef IOCTL_LOAD_LEN_CHECK_EN
   ,parameter int unsigned ROM_BYTES  = 65536
`endif
) (
    input  logic clk_12,
    input  logic RESET_L,
    input  logic rom_dl,
    input  logic rom_acc,
    input  logic reset_req,
    output logic load_entry,
    output logic core_reset_l,
`ifdef IOCTL_LOAD_LEN_CHECK_EN
    output logic load_short,
`endif
    output logic load_busy
);

    localparam logic [7:0] HOLD_INIT = 8'(RESET_HOLD);

    state_e     state, state_nxt;
    logic [7:0] hold_cnt, hold_nxt;

`ifdef IOCTL_LOAD_LEN_CHECK_EN
    localparam logic [16:0] LEN_SAT  = 17'h10000;
    localparam logic [16:0] LEN_NEED = 17'(ROM_BYTES);
    logic [16:0] len_cnt;
`endif

    // Any ROM download start jumps straight into LOAD, from every state.
    assign load_entry = rom_dl && (state != LOAD);

    // Next-state and hold counter; rom_dl outranks reset_req everywhere.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        case (state)
            LOAD: begin
                if (!rom_dl) begin
`ifdef IOCTL_LOAD_LEN_CHECK_EN
                    if (len_cnt < LEN_NEED) begin
                        state_nxt = HALT;
                    end else begin
                        state_nxt = SETTLE;
                        hold_nxt  = HOLD_INIT;
                    end
`else
                    state_nxt = SETTLE;
                    hold_nxt  = HOLD_INIT;
`endif
                end
            end
            SETTLE: begin
                if (rom_dl) begin
                    state_nxt = LOAD;
                end else if (reset_req) begin
                    hold_nxt = HOLD_INIT;
                end else if (hold_cnt == 8'd1) begin
                    state_nxt = RUN;
                end else begin
                    hold_nxt = hold_cnt - 8'd1;
                end
            end
            RUN: begin
                if (rom_dl) begin
                    state_nxt = LOAD;
                end else if (reset_req) begin
                    state_nxt = SETTLE;
                    hold_nxt  = HOLD_INIT;
                end
            end
            default: begin
`ifdef IOCTL_LOAD_LEN_CHECK_EN
                // HALT: only a fresh download gets the core out of here.
                if (rom_dl) state_nxt = LOAD;
`else
                // HALT is unreachable without the length check; recover.
                state_nxt = SETTLE;
                hold_nxt  = HOLD_INIT;
`endif
            end
        endcase
    end

    // State, hold counter and the registered state-decoded outputs.
    always_ff @(posedge clk_12 or negedge RESET_L) begin
        if (!RESET_L) begin
            state        <= SETTLE;
            hold_cnt     <= HOLD_INIT;
            core_reset_l <= 1'b0;
            load_busy    <= 1'b0;
`ifdef IOCTL_LOAD_LEN_CHECK_EN
            load_short   <= 1'b0;
`endif
        end else begin
            state        <= state_nxt;
            hold_cnt     <= hold_nxt;
            core_reset_l <= (state_nxt == RUN);
            load_busy    <= (state_nxt == LOAD);
`ifdef IOCTL_LOAD_LEN_CHECK_EN
            load_short   <= (state_nxt == HALT);
`endif
        end
    end

`ifdef IOCTL_LOAD_LEN_CHECK_EN
    // Accepted-byte count for the current load; a byte on the entry cycle
    // already belongs to the new load. Saturates at 64 KiB.
    always_ff @(posedge clk_12 or negedge RESET_L) begin
        if (!RESET_L) begin
            len_cnt <= '0;
        end else if (load_entry) begin
            len_cnt <= {16'd0, rom_acc};
        end else if (state == LOAD && rom_acc && len_cnt != LEN_SAT) begin
            len_cnt <= len_cnt + 17'd1;
        end
    end
`endif

endmodule

// File: rtl/ioctl_load_sched.sv
// ioctl_load_sched: decodes the hps_io ioctl stream for the Black Widow core
// (ROM bytes, game-select byte, DIP bytes) and sequences the core reset.
// Optional build macro: IOCTL_LOAD_LEN_CHECK_EN (ROM length check + HALT,
// adds the load_short output).
module ioctl_load_sched
    import ioctl_load_pkg::*;
#(
    parameter int unsigned RESET_HOLD = 16,
    parameter int unsigned ROM_BYTES  = 65536,
    parameter int unsigned DIP_BYTES  = 8
) (
    input  logic        clk_12,
    input  logic        RESET_L,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    input  logic        reset_req,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic [3:0]  mod_sel,
    output logic        mod_invalid,
    output logic [63:0] dip_bank,
`ifdef IOCTL_LOAD_LEN_CHECK_EN
    output logic        load_short,
`endif
    output logic        core_reset_l,
    output logic        load_busy,
    output logic        addr_ovf
);

    logic rom_dl, rom_wr, rom_hi_zero, rom_acc, load_entry;
    logic mod_wr, dip_wr;
    logic [7:0][7:0] dip_q;

    assign rom_dl      = ioctl_download && (ioctl_index == IDX_ROM);
    assign rom_wr      = ioctl_wr && rom_dl;
    assign rom_hi_zero = (ioctl_addr[24:16] == 9'd0);
    assign rom_acc     = rom_wr && rom_hi_zero;
    assign mod_wr      = ioctl_wr && (ioctl_index == IDX_MOD);
    // Bytes at or beyond DIP_BYTES are never written and read back as zero.
    assign dip_wr      = ioctl_wr && (ioctl_index == IDX_DIP) &&
                         (ioctl_addr < 25'(DIP_BYTES));
    assign dip_bank    = dip_q;

    ioctl_load_fsm #(
        .RESET_HOLD (RESET_HOLD)
`ifdef IOCTL_LOAD_LEN_CHECK_EN
       ,.ROM_BYTES  (ROM_BYTES)
`endif
    ) u_fsm (
        .clk_12       (clk_12),
        .RESET_L      (RESET_L),
        .rom_dl       (rom_dl),
        .rom_acc      (rom_acc),
        .reset_req    (reset_req),
        .load_entry   (load_entry),
        .core_reset_l (core_reset_l),
`ifdef IOCTL_LOAD_LEN_CHECK_EN
        .load_short   (load_short),
`endif
        .load_busy    (load_busy)
    );

    // ROM write port: one-cycle registered copy of each in-range byte.
    always_ff @(posedge clk_12 or negedge RESET_L) begin
        if (!RESET_L) begin
            dn_wr   <= 1'b0;
            dn_addr <= '0;
            dn_data <= '0;
        end else begin
            dn_wr <= rom_acc;
            if (rom_acc) begin
                dn_addr <= ioctl_addr[15:0];
                dn_data <= ioctl_dout;
            end
        end
    end

    // Sticky out-of-range flag; a bad byte on the entry cycle still counts.
    always_ff @(posedge clk_12 or negedge RESET_L) begin
        if (!RESET_L) begin
            addr_ovf <= 1'b0;
        end else if (rom_wr && !rom_hi_zero) begin
            addr_ovf <= 1'b1;
        end else if (load_entry) begin
            addr_ovf <= 1'b0;
        end
    end

    // Game select: last mod byte wins; codes above 3 select nothing.
    always_ff @(posedge clk_12 or negedge RESET_L) begin
        if (!RESET_L) begin
            mod_sel     <= mod_onehot(MOD_BWIDOW);
            mod_invalid <= 1'b0;
        end else if (mod_wr) begin
            if (ioctl_dout < 8'd4) begin
                mod_sel     <= mod_onehot(mod_e'(ioctl_dout[1:0]));
                mod_invalid <= 1'b0;
            end else begin
                mod_sel     <= 4'b0000;
                mod_invalid <= 1'b1;
            end
        end
    end

    // DIP bank bytes, addressed by the low address bits.
    always_ff @(posedge clk_12 or negedge RESET_L) begin
        if (!RESET_L) begin
            dip_q <= '0;
        end else if (dip_wr) begin
            dip_q[ioctl_addr[2:0]] <= ioctl_dout;
        end
    end

endmodule

// File: tb/tb_ioctl_load_sched.sv
// tb_ioctl_load_sched: directed checks of ROM/mod/DIP decode and the core
// reset sequencing. The trailing HALT segment exists only when
// IOCTL_LOAD_LEN_CHECK_EN is defined; the earlier steps assume the default build.
module tb_ioctl_load_sched;
    import ioctl_load_pkg::*;

    logic        clk_12 = 1'b0;
    logic        RESET_L;
    logic        ioctl_download, ioctl_wr, reset_req;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout, ioctl_index;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr, mod_invalid, core_reset_l, load_busy, addr_ovf;
    logic [3:0]  mod_sel;
    logic [63:0] dip_bank;
`ifdef IOCTL_LOAD_LEN_CHECK_EN
    logic        load_short;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk_12 = ~clk_12;

    ioctl_load_sched #(
        .RESET_HOLD (16),
        .ROM_BYTES  (4),
        .DIP_BYTES  (8)
    ) dut (
        .clk_12         (clk_12),
        .RESET_L        (RESET_L),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .reset_req      (reset_req),
        .dn_addr        (dn_addr),
        .dn_data        (dn_data),
        .dn_wr          (dn_wr),
        .mod_sel        (mod_sel),
        .mod_invalid    (mod_invalid),
        .dip_bank       (dip_bank),
`ifdef IOCTL_LOAD_LEN_CHECK_EN
        .load_short     (load_short),
`endif
        .core_reset_l   (core_reset_l),
        .load_busy      (load_busy),
        .addr_ovf       (addr_ovf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance n clocks, landing 1 time unit after the last rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk_12);
        #1;
    endtask

    initial begin
        RESET_L = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; reset_req = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0; ioctl_index = '0;
        step(3);
        chk("rst_dn_wr",   dn_wr, 0);
        chk("rst_dn_addr", dn_addr, 0);
        chk("rst_dn_data", dn_data, 0);
        chk("rst_mod_sel", mod_sel, 4'b0001);
        chk("rst_mod_inv", mod_invalid, 0);
        chk("rst_dip",     dip_bank, 0);
        chk("rst_core",    core_reset_l, 0);
        chk("rst_busy",    load_busy, 0);
        chk("rst_ovf",     addr_ovf, 0);

        // Power-on settle: 16 cycles in reset, then RUN.
        RESET_L = 1'b1;
        step(15);
        chk("po_hold15", core_reset_l, 0);
        step(1);
        chk("po_run", core_reset_l, 1);
        chk("po_mod", mod_sel, 4'b0001);

        // ROM download, three back-to-back bytes.
        ioctl_download = 1'b1; ioctl_index = IDX_ROM;
        step(1);
        chk("ld_core", core_reset_l, 0);
        chk("ld_busy", load_busy, 1);
        ioctl_wr = 1'b1; ioctl_addr = 25'h0000000; ioctl_dout = 8'hA5;
        step(1);
        chk("rom0_wr", dn_wr, 1); chk("rom0_a", dn_addr, 16'h0000); chk("rom0_d", dn_data, 8'hA5);
        ioctl_addr = 25'h0000001; ioctl_dout = 8'h5A;
        step(1);
        chk("rom1_wr", dn_wr, 1); chk("rom1_a", dn_addr, 16'h0001); chk("rom1_d", dn_data, 8'h5A);
        ioctl_addr = 25'h0000002; ioctl_dout = 8'hFF;
        step(1);
        chk("rom2_wr", dn_wr, 1); chk("rom2_a", dn_addr, 16'h0002); chk("rom2_d", dn_data, 8'hFF);
        ioctl_wr = 1'b0;
        step(1);
        chk("rom_idle_wr", dn_wr, 0);
        chk("rom_hold_a",  dn_addr, 16'h0002);
        chk("rom_hold_d",  dn_data, 8'hFF);
        ioctl_download = 1'b0;
        step(1);
        chk("ldx_busy", load_busy, 0);
        chk("ldx_core", core_reset_l, 0);
        step(15);
        chk("ldx_hold15", core_reset_l, 0);
        step(1);
        chk("ldx_run", core_reset_l, 1);

        // Out-of-range ROM address.
        ioctl_download = 1'b1;
        step(1);
        ioctl_wr = 1'b1; ioctl_addr = 25'h0010000; ioctl_dout = 8'h11;
        step(1);
        ioctl_wr = 1'b0;
        chk("ovf_set",   addr_ovf, 1);
        chk("ovf_no_wr", dn_wr, 0);
        chk("ovf_addr",  dn_addr, 16'h0002);
        ioctl_download = 1'b0;
        step(1);
        chk("ovf_sticky", addr_ovf, 1);
        ioctl_download = 1'b1;
        step(1);
        chk("ovf_clear", addr_ovf, 0);
        ioctl_download = 1'b0;
        step(17);
        chk("ovf_run", core_reset_l, 1);

        // Mod byte.
        ioctl_index = IDX_MOD; ioctl_addr = 25'd5; ioctl_wr = 1'b1; ioctl_dout = 8'h02;
        step(1);
        chk("mod2_sel", mod_sel, 4'b0100);
        chk("mod2_inv", mod_invalid, 0);
        ioctl_dout = 8'h07;
        step(1);
        chk("mod7_sel", mod_sel, 4'b0000);
        chk("mod7_inv", mod_invalid, 1);
        ioctl_dout = 8'h03;
        step(1);
        chk("mod3_sel", mod_sel, 4'b1000);
        chk("mod3_inv", mod_invalid, 0);
        chk("mod_core", core_reset_l, 1);

        // DIP bytes.
        ioctl_index = IDX_DIP; ioctl_addr = 25'd1; ioctl_dout = 8'h3C;
        step(1);
        chk("dip1", dip_bank, 64'h0000_0000_0000_3C00);
        ioctl_addr = 25'd9; ioctl_dout = 8'h77;
        step(1);
        chk("dip9_ign", dip_bank, 64'h0000_0000_0000_3C00);
        ioctl_addr = 25'd7; ioctl_dout = 8'h81;
        step(1);
        chk("dip7", dip_bank, 64'h8100_0000_0000_3C00);
        ioctl_addr = 25'd8; ioctl_dout = 8'h55;
        step(1);
        chk("dip8_ign", dip_bank, 64'h8100_0000_0000_3C00);
        chk("dip_core", core_reset_l, 1);
        ioctl_wr = 1'b0; ioctl_index = IDX_ROM; ioctl_addr = '0;

        // One-cycle reset request from RUN.
        reset_req = 1'b1;
        step(1);
        reset_req = 1'b0;
        chk("rq_low", core_reset_l, 0);
        step(15);
        chk("rq_hold15", core_reset_l, 0);
        step(1);
        chk("rq_run", core_reset_l, 1);

        // Held reset request keeps reloading the counter.
        reset_req = 1'b1;
        step(20);
        chk("rqh_low", core_reset_l, 0);
        reset_req = 1'b0;
        step(15);
        chk("rqh_hold15", core_reset_l, 0);
        step(1);
        chk("rqh_run", core_reset_l, 1);

        // Download beats a simultaneous reset request.
        reset_req = 1'b1; ioctl_download = 1'b1;
        step(1);
        chk("prio_busy", load_busy, 1);
        reset_req = 1'b0;

        // Reset mid-download, then release with the download still high.
        RESET_L = 1'b0;
        #1;
        chk("mid_busy", load_busy, 0);
        chk("mid_dip",  dip_bank, 0);
        chk("mid_mod",  mod_sel, 4'b0001);
        chk("mid_core", core_reset_l, 0);
        step(2);
        RESET_L = 1'b1;
        step(1);
        chk("mid_reload", load_busy, 1);

`ifdef IOCTL_LOAD_LEN_CHECK_EN
        // Short image (3 of 4 bytes) parks in HALT.
        ioctl_wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ioctl_addr = 25'(i); ioctl_dout = 8'(i + 1);
            step(1);
        end
        ioctl_wr = 1'b0; ioctl_download = 1'b0;
        step(1);
        chk("halt_short", load_short, 1);
        chk("halt_core",  core_reset_l, 0);
        reset_req = 1'b1;
        step(20);
        reset_req = 1'b0;
        step(20);
        chk("halt_stay", core_reset_l, 0);
        ioctl_download = 1'b1;
        step(1);
        chk("halt_exit", load_busy, 1);
        chk("halt_clr",  load_short, 0);
        ioctl_wr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ioctl_addr = 25'(i); ioctl_dout = 8'(i + 1);
            step(1);
        end
        ioctl_wr = 1'b0; ioctl_download = 1'b0;
        step(1);
        chk("full_short", load_short, 0);
        step(16);
        chk("full_run", core_reset_l, 1);
`else
        ioctl_download = 1'b0;
        step(1);
        chk("end_busy", load_busy, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ioctl_load_sched.md
Name: ioctl_load_sched

Overview:
- Sequences everything the HPS ioctl stream drives into the Black Widow family core: ROM bytes to the core download port, game-select (mod) byte, and DIP bank bytes.
- Owns the core reset: holds it through ROM download, external reset requests and a post-load settle window.
- Sits between hps_io and BWIDOW_TOP, in the clk_12 domain.

Parameters:
RESET_HOLD, 16, cycles core reset stays asserted after the last reset cause clears (1..255).
ROM_BYTES, 65536, expected ROM image length in bytes (used only with the optional feature).
DIP_BYTES, 8, number of DIP bank bytes accepted on index 254 (1..8).

Ports:
clk_12  in  1  system clock; all logic on its rising edge.
RESET_L  in  1  asynchronous active-low reset.
ioctl_download  in  1  download active, from hps_io.
ioctl_wr  in  1  one-cycle byte strobe.
ioctl_addr  in  25  byte address.
ioctl_dout  in  8  byte data.
ioctl_index  in  8  stream index: 0 ROM, 1 mod, 254 DIP.
reset_req  in  1  OR of OSD reset and user button, level.
dn_addr  out  16  ROM write address to core.
dn_data  out  8  ROM write data.
dn_wr  out  1  ROM write strobe.
mod_sel  out  4  one-hot {spacduel,lunarbat,gravitar,bwidow}.
mod_invalid  out  1  last mod byte was greater than 3.
dip_bank  out  64  DIP bytes; byte n is at [8n+7:8n].
core_reset_l  out  1  active-low reset to core.
load_busy  out  1  high in LOAD state.
addr_ovf  out  1  sticky; a ROM byte arrived with ioctl_addr[24:16] != 0.

Behaviour:
- Reset values:
  - dn_addr=0, dn_data=0, dn_wr=0.
  - mod_sel=4'b0001, mod_invalid=0, dip_bank=0.
  - core_reset_l=0, load_busy=0, addr_ovf=0.
  - FSM=SETTLE, hold counter=RESET_HOLD.
- Definitions:
  - rom_dl = ioctl_download && ioctl_index==0.
  - rom_wr = ioctl_wr && rom_dl.
- ROM path (registered, 1-cycle latency):
  - On rom_wr with ioctl_addr[24:16]==0: next cycle dn_wr=1 for exactly one cycle, with dn_addr=ioctl_addr[15:0] and dn_data=ioctl_dout.
  - If ioctl_addr[24:16]!=0: no dn_wr, addr_ovf set. addr_ovf clears only on entering LOAD.
  - dn_addr and dn_data hold their last values while dn_wr=0.
  - Back-to-back strobes on consecutive cycles produce back-to-back dn_wr pulses; no byte is dropped.
- Mod path:
  - On ioctl_wr with index 1 (any address; last byte wins), update mod_sel the next cycle.
  - Values 0..3 set the matching one-hot bit and clear mod_invalid.
  - Values 4..255 set mod_sel=0 and mod_invalid=1.
- DIP path:
  - On ioctl_wr with index 254 and ioctl_addr < DIP_BYTES, write byte ioctl_addr[2:0] of dip_bank.
  - Other addresses are ignored.
  - DIP and mod writes never touch core_reset_l.
- FSM:
  - LOAD: core_reset_l=0, load_busy=1. Stays while rom_dl. When rom_dl falls, go to SETTLE and reload the counter.
  - SETTLE: core_reset_l=0. Counter decrements each cycle.
    - rom_dl → LOAD.
    - reset_req → reload counter, stay.
    - Counter==1 with neither cause → RUN.
  - RUN: core_reset_l=1. rom_dl → LOAD; else reset_req → SETTLE with reload.
  - rom_dl takes priority over reset_req in every state.
  - core_reset_l is a registered output: it rises on the first cycle in RUN and falls on the first cycle in LOAD/SETTLE.
- RESET_L asserted mid-download:
  - All state returns to reset values.
  - After release, if rom_dl is still high, the FSM goes SETTLE→LOAD on the first clock.

Optional Feature:
- Macro: IOCTL_LOAD_LEN_CHECK_EN.
- With it:
  - A 17-bit counter counts accepted ROM bytes in LOAD; it clears on entry to LOAD.
  - On leaving LOAD, if count < ROM_BYTES, enter HALT and set extra output load_short=1.
  - HALT keeps core_reset_l=0 and exits only to LOAD on a new rom_dl.
  - The count saturates at 65536.
- Without it:
  - No counter, no HALT state, no load_short port.
  - LOAD always exits to SETTLE.

Decomposition:
- Package ioctl_load_pkg holds:
  - IDX_ROM=8'd0, IDX_MOD=8'd1, IDX_DIP=8'd254.
  - The state enum {SETTLE, LOAD, RUN, HALT}.
  - The mod enum {MOD_BWIDOW, MOD_GRAVITAR, MOD_LUNARBAT, MOD_SPACDUEL}.
- One natural sub-module: ioctl_load_fsm (state, hold counter, optional length counter, core_reset_l). Decode and registers stay in the top.

Test Plan:
- Release RESET_L with no activity → core_reset_l stays 0 for 16 cycles, then goes 1; mod_sel=0001.
- ROM download, 3 strobes at addr 0x0000/0x0001/0x0002 with data A5/5A/FF on consecutive cycles → three dn_wr pulses, each 1 cycle later, correct addr/data; core_reset_l=0 through LOAD plus 16 cycles.
- ROM strobe at addr 0x10000 → no dn_wr; addr_ovf=1; the next LOAD entry clears it.
- Index 1 byte 0x02 → mod_sel=0100; byte 0x07 → mod_sel=0000, mod_invalid=1. Index 254 addr 1 data 0x3C → dip_bank[15:8]=0x3C; addr 9 ignored.
- In RUN, pulse reset_req 1 cycle → core_reset_l low for 16 cycles. reset_req held during SETTLE → counter reloads every cycle until release.
- With IOCTL_LOAD_LEN_CHECK_EN and ROM_BYTES=4, download 3 bytes → HALT, load_short=1, core_reset_l=0. Then download 4 bytes → SETTLE, then RUN.
